// File: rtl/pcm_feeder.sv
// PCM sample feeder: processor-written FIFO feeding the I2S transmitter handshake.
// Optional attenuation shifter enabled by defining PCM_FEEDER_VOLUME_EN.
//
// state    | meaning
// IDLE     | waiting for run && tx_ready; selects FIFO head or silence
// SEND     | registers pcm_out and raises sent for one cycle
// WAIT_LOW | holds pcm_out until transmitter drops tx_ready
module pcm_feeder #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     wr_en,
  input  logic [23:0]              wr_data,
  input  logic                     run,
  input  logic [3:0]               vol,
  input  logic                     clr_stats,
  input  logic                     tx_ready,
  output logic [23:0]              pcm_out,
  output logic                     sent,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     fifo_full,
  output logic                     fifo_empty,
  output logic                     overflow,
  output logic [CNT_W-1:0]         underrun_cnt
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_LOW} state_t;

  state_t       state;
  logic [23:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [23:0]  sample_q;
  logic [23:0]  shaped;
  logic         grant;
  logic         pop;
  logic         push;

  assign fifo_full  = (fifo_count == (AW+1)'(DEPTH));
  assign fifo_empty = (fifo_count == '0);

  assign grant = (state == IDLE) && run && tx_ready;
  assign pop   = grant && !fifo_empty;
  // A write into a full FIFO still lands when the head leaves in the same cycle.
  assign push  = wr_en && (!fifo_full || pop);

`ifdef PCM_FEEDER_VOLUME_EN
  assign shaped = $signed(sample_q) >>> vol;
`else
  logic unused_vol;
  assign unused_vol = ^vol;
  assign shaped = sample_q;
`endif

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      sample_q <= '0;
      pcm_out  <= '0;
      sent     <= 1'b0;
    end else begin
      sent <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            sample_q <= fifo_empty ? 24'h0 : mem[rd_ptr];
            state    <= SEND;
          end
        end
        SEND: begin
          pcm_out <= shaped;
          sent    <= 1'b1;
          state   <= WAIT_LOW;
        end
        WAIT_LOW: begin
          if (!tx_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      overflow     <= 1'b0;
      underrun_cnt <= '0;
    end else if (clr_stats) begin
      overflow     <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      if (wr_en && !push) overflow <= 1'b1;
      if (grant && fifo_empty && (underrun_cnt != '1))
        underrun_cnt <= underrun_cnt + 1'b1;
    end
  end

endmodule
